// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the fabric clock/reset conditioner.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_CLK_HZ             = 100_000_000;
  localparam int DEF_US_DIV             = DEF_CLK_HZ / 1_000_000;
  localparam int DEF_MS_DIV             = 1000;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;

  // Bits needed to hold 0..max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/clk_rst_tick_gen_tick_divider.sv
// Wrapping 0..DIV-1 counter; tick is the lookahead strobe for the wrap cycle.
module tick_divider
  import clk_rst_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = en && !clr && (cnt_q == LAST);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_rst_tick_gen.sv
// Lock qualification, system reset sequencing and 1 us / 1 ms tick generation
// for the touchscreen fabric logic.
module clk_rst_tick_gen
  import clk_rst_pkg::*;
#(
  parameter int CLK_HZ             = DEF_CLK_HZ,
  parameter int US_DIV             = CLK_HZ / 1_000_000,
  parameter int MS_DIV             = DEF_MS_DIV,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES
) (
  input  logic FAB_CLK,
  input  logic RESET,
  input  logic LOCK,
  input  logic SW_RESET_REQ,
  input  logic LOCK_LOST_CLR,
  output logic SYS_RESET,
  output logic READY,
  output logic TICK_US,
  output logic TICK_MS,
  output logic LOCK_LOST
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int            CW          = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

  logic          lock_meta_q;
  logic          lock_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_lost_q, lock_lost_d;
  logic          sys_reset_q, ready_q;
  logic          tick_us_q, tick_ms_q;
  logic          run_d;
  logic          tick_us_d, tick_ms_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (SW_RESET_REQ) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // Lock loss outranks a soft-reset request arriving on the same cycle.
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (SW_RESET_REQ) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    if ((state_q == RUN) && !lock_s_q) begin
      lock_lost_d = 1'b1;
    end else if (LOCK_LOST_CLR) begin
      lock_lost_d = 1'b0;
    end

    run_d = (state_d == RUN);
  end

  // Dividers run on the next-state so their strobes can be registered and
  // still land on the US_DIV-th cycle of RUN.
  tick_divider #(.DIV(US_DIV)) u_us_div (
    .clk  (FAB_CLK),
    .rst  (RESET),
    .en   (run_d),
    .clr  (!run_d),
    .tick (tick_us_d)
  );

  tick_divider #(.DIV(MS_DIV)) u_ms_div (
    .clk  (FAB_CLK),
    .rst  (RESET),
    .en   (tick_us_d),
    .clr  (!run_d),
    .tick (tick_ms_d)
  );

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      tick_us_q   <= 1'b0;
      tick_ms_q   <= 1'b0;
    end else begin
      lock_meta_q <= LOCK;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
      sys_reset_q <= !run_d;
      ready_q     <= run_d;
      tick_us_q   <= tick_us_d;
      tick_ms_q   <= tick_ms_d;
    end
  end

  assign SYS_RESET = sys_reset_q;
  assign READY     = ready_q;
  assign TICK_US   = tick_us_q;
  assign TICK_MS   = tick_ms_q;
  assign LOCK_LOST = lock_lost_q;

endmodule
